// File: rtl/mult_div_param.sv
// mult_div_param: iterative shift-add multiplier / restoring divider with signed fix-up
module mult_div_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, neg_p, neg_r, dz;
    logic [WIDTH-1:0]   mag_b, acc_hi, acc_lo;
    logic               sa, sb, accept, ge;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_s, sub_r, sub_d;
    logic [2*WIDTH-1:0] prod;
    // -2^(WIDTH-1) negates to itself, which is already the correct unsigned magnitude
    assign sa     = sign & a[WIDTH-1];
    assign sb     = sign & b[WIDTH-1];
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;
    assign accept = start & (op == 2'b01 | op == 2'b10);
    assign add_s  = {1'b0, acc_hi} + {1'b0, acc_lo[0] ? mag_b : {WIDTH{1'b0}}};
    assign sub_r  = {acc_hi, acc_lo[WIDTH-1]};
    assign sub_d  = sub_r - {1'b0, mag_b};
    assign ge     = sub_r >= {1'b0, mag_b};
    assign prod   = neg_p ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign busy   = state == RUN | state == FIX;
    assign done   = state == DONE;
    assign div_zero = dz;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_div <= op[1];
                    neg_p  <= sa ^ sb;
                    neg_r  <= sa;
                    mag_b  <= abs_b;
                    acc_hi <= '0;
                    acc_lo <= abs_a;
                    cnt    <= '0;
                    dz     <= op[1] & (b == '0);
                    state  <= (op[1] & (b == '0)) ? DONE : RUN;
                end
                RUN: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= is_div ? (ge ? sub_d[WIDTH-1:0] : sub_r[WIDTH-1:0]) : add_s[WIDTH:1];
                    acc_lo <= is_div ? {acc_lo[WIDTH-2:0], ge} : {add_s[0], acc_lo[WIDTH-1:1]};
                    state  <= (cnt == CNT_W'(WIDTH - 1)) ? FIX : RUN;
                end
                FIX: begin
                    hi    <= is_div ? (neg_r ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
                    lo    <= is_div ? (neg_p ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
                    state <= DONE;
                end
                default: begin
                    dz    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_param.sv
// tb_mult_div_param: vector table + scoreboard bench for mult_div_param (WIDTH 32 and 8)
module tb_mult_div_param;
    localparam int W = 32;
    logic         clk = 0, reset = 0, start = 0, sign = 0;
    logic [1:0]   op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic         start8 = 0, sign8 = 0;
    logic [1:0]   op8 = 0;
    logic [7:0]   a8 = 0, b8 = 0;
    logic         busy8, done8, div_zero8;
    logic [7:0]   hi8, lo8;
    int checks = 0, errors = 0;
    logic [W-1:0] last_hi = 0, last_lo = 0;

    typedef struct {
        logic [1:0]   op;
        logic         sign;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;
    vec_t exp_q[$];
    vec_t tbl[14];

    mult_div_param #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));
    mult_div_param #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .sign(sign8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t model(input logic [1:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] ph, input logic [W-1:0] pl);
        vec_t v;
        logic signed [2*W-1:0] xs, ys, p, q, r;
        v.op = o; v.sign = s; v.a = x; v.b = y; v.dz = 0;
        xs = {{W{s & x[W-1]}}, x};
        ys = {{W{s & y[W-1]}}, y};
        if (o == 2'b01) begin
            p = xs * ys;
            v.hi = p[2*W-1:W]; v.lo = p[W-1:0];
        end else if (y == 0) begin
            v.hi = ph; v.lo = pl; v.dz = 1;
        end else begin
            q = xs / ys; r = xs % ys;
            v.hi = r[W-1:0]; v.lo = q[W-1:0];
        end
        return v;
    endfunction

    task automatic run(input vec_t v, input bit noisy);
        vec_t e;
        int k = 0;
        int exp_lat;
        bit ok = 1;
        exp_lat = (v.op == 2'b10 && v.b == 0) ? 0 : W + 1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1; op = v.op; sign = v.sign; a = v.a; b = v.b;
        @(posedge clk);
        @(negedge clk);
        while (!done && k < W + 8) begin
            if (busy !== 1'b1 || div_zero !== 1'b0) ok = 0;
            if (noisy) begin
                start = 1'($urandom); op = 2'($urandom); sign = 1'($urandom); a = $urandom; b = $urandom;
            end else start = 0;
            @(posedge clk); k++; @(negedge clk);
        end
        start = 0;
        e = exp_q.pop_front();
        check("done_seen", done, 1);
        check("latency", k, exp_lat);
        check("busy_window", ok, 1);
        if (done) begin
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("div_zero", div_zero, e.dz);
            check("busy_in_done", busy, 0);
        end
        last_hi = e.hi; last_lo = e.lo;
        @(posedge clk); @(negedge clk);
        check("done_pulse_one_cycle", done, 0);
        check("dz_low_after_done", div_zero, 0);
    endtask

    initial begin
        vec_t v;
        int k;
        bit seen;
        tbl[0]  = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
        tbl[1]  = '{2'b01, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tbl[2]  = '{2'b10, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[4]  = '{2'b10, 1'b0, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0};
        tbl[5]  = '{2'b10, 1'b0, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1};
        tbl[6]  = '{2'b01, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[8]  = '{2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[9]  = '{2'b10, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[10] = '{2'b10, 1'b0, 32'h00000003, 32'h0000000A, 32'h00000003, 32'h00000000, 1'b0};
        tbl[11] = '{2'b10, 1'b1, 32'hFFFFFFF8, 32'h00000000, 32'h00000003, 32'h00000000, 1'b1};
        tbl[12] = '{2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[13] = '{2'b10, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};

        // reset state, with start held high to show it is discarded
        start = 1; op = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0); check("rst_lo", lo, 0);
        reset = 1; start = 0;
        @(posedge clk); @(negedge clk);
        check("start_discarded", busy, 0);

        for (int i = 0; i < 14; i++) run(tbl[i], i[0]);

        // no-op encodings must leave everything untouched
        @(negedge clk); start = 1; op = 2'b00; a = 5; b = 7;
        @(posedge clk); @(negedge clk);
        check("noop00_busy", busy, 0); check("noop00_done", done, 0);
        op = 2'b11;
        @(posedge clk); @(negedge clk);
        check("noop11_busy", busy, 0); check("noop11_done", done, 0);
        check("noop_hi", hi, last_hi); check("noop_lo", lo, last_lo);
        start = 0;

        for (int i = 0; i < 20; i++) begin
            logic [1:0] o;
            logic s;
            logic [W-1:0] x, y;
            o = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 9)) : $urandom;
            run(model(o, s, x, y, last_hi, last_lo), i[0]);
        end

        // abort: restart pulse at edge 5 is ignored, reset at edge 10 kills the op
        seen = 0;
        @(negedge clk); start = 1; op = 2'b01; sign = 0; a = 32'd1234; b = 32'd5678;
        @(posedge clk);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            seen |= done;
            start = (e == 4 || e == 9); a = 32'hDEADBEEF; b = 32'h12345678;
            if (e == 9) reset = 0;
            @(posedge clk);
        end
        @(negedge clk);
        check("abort_no_done", seen, 0);
        check("abort_busy", busy, 0); check("abort_done", done, 0); check("abort_dz", div_zero, 0);
        check("abort_hi", hi, 0); check("abort_lo", lo, 0);
        reset = 1; start = 0; last_hi = 0; last_lo = 0;
        @(posedge clk); @(negedge clk);
        check("abort_idle", busy, 0);
        run(model(2'b01, 1'b1, 32'hFFFFFFF9, 32'd9, last_hi, last_lo), 0);

        // WIDTH=8 instance: 200 / 7
        @(negedge clk); start8 = 1; op8 = 2'b10; sign8 = 0; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); k = 0; @(negedge clk); start8 = 0;
        while (!done8 && k < 20) begin @(posedge clk); k++; @(negedge clk); end
        check("w8_latency", k, 9);
        check("w8_lo", lo8, 28); check("w8_hi", hi8, 4); check("w8_dz", div_zero8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
